// File: rtl/ccip_rd_req_arbiter.sv
// Round-robin arbiter for the CCI-P TX0 read-request channel. It stamps the
// requester ID into the upper mdata bits, meters credits, and steers responses.
module ccip_rd_req_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int REQ_ID_WIDTH    = 2,
    parameter int HDR_WIDTH       = 64,
    parameter int TAG_WIDTH       = 16,
    parameter int MAX_OUTSTANDING = 256,
    parameter int CREDIT_WIDTH    = 9
) (
    input  logic                           clk,
    input  logic                           bb_softreset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*HDR_WIDTH-1:0]   req_hdr,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]   req_mdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           out_valid,
    output logic [HDR_WIDTH-1:0]           out_hdr,
    output logic [TAG_WIDTH-1:0]           out_mdata,
    input  logic                           out_almfull,
    input  logic                           rsp_valid,
    input  logic [TAG_WIDTH-1:0]           rsp_mdata,
    output logic [NUM_REQ-1:0]             rsp_valid_o,
    output logic [TAG_WIDTH-1:0]           rsp_mdata_o,
    output logic [CREDIT_WIDTH-1:0]        outstanding,
    output logic                           err_underflow
);
    localparam int LOW_W = TAG_WIDTH - REQ_ID_WIDTH;

    logic [REQ_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic                    out_valid_q, out_valid_d;
    logic [HDR_WIDTH-1:0]    out_hdr_q, out_hdr_d;
    logic [TAG_WIDTH-1:0]    out_mdata_q, out_mdata_d;
    logic [NUM_REQ-1:0]      rsp_valid_o_q, rsp_valid_o_d;
    logic [TAG_WIDTH-1:0]    rsp_mdata_o_q, rsp_mdata_o_d;
    logic [CREDIT_WIDTH-1:0] outstanding_q, outstanding_d;
    logic                    err_underflow_q, err_underflow_d;

    logic                    can_issue;
    logic [NUM_REQ-1:0]      grant;
    logic [REQ_ID_WIDTH-1:0] gnt_id;
    logic                    handshake;
    logic [HDR_WIDTH-1:0]    gnt_hdr;
    logic [TAG_WIDTH-1:0]    gnt_mdata;
    logic [REQ_ID_WIDTH-1:0] rsp_id;
    logic                    unused_mdata_hi;

    // A response arriving this cycle does not free a credit until next cycle.
    assign can_issue = ~out_almfull & (outstanding_q < CREDIT_WIDTH'(MAX_OUTSTANDING));

    always_comb begin
        int  idx;
        logic found;
        grant  = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                gnt_id      = REQ_ID_WIDTH'(idx);
            end
        end
        if (!can_issue || !bb_softreset_n) begin
            grant = '0;
        end
    end

    // Handshake: a transfer happens in the cycle where req_valid[g] and
    // req_ready[g] are both high; requesters hold valid and payload until then.
    assign req_ready = grant;
    assign handshake = |(req_valid & grant);

    always_comb begin
        gnt_hdr   = '0;
        gnt_mdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_hdr   = req_hdr[i*HDR_WIDTH +: HDR_WIDTH];
                gnt_mdata = {REQ_ID_WIDTH'(i), req_mdata[i*TAG_WIDTH +: LOW_W]};
            end
        end
    end

    // The requester ID overwrites the upper mdata bits, so those inputs are ignored.
    always_comb begin
        unused_mdata_hi = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            unused_mdata_hi = unused_mdata_hi ^ (^req_mdata[i*TAG_WIDTH+LOW_W +: REQ_ID_WIDTH]);
        end
    end

    assign rsp_id = rsp_mdata[TAG_WIDTH-1 -: REQ_ID_WIDTH];

    always_comb begin
        rr_ptr_d        = rr_ptr_q;
        out_valid_d     = handshake;
        out_hdr_d       = out_hdr_q;
        out_mdata_d     = out_mdata_q;
        rsp_valid_o_d   = '0;
        rsp_mdata_o_d   = rsp_mdata_o_q;
        outstanding_d   = outstanding_q;
        err_underflow_d = err_underflow_q;

        if (handshake) begin
            rr_ptr_d    = (gnt_id == REQ_ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_id + REQ_ID_WIDTH'(1);
            out_hdr_d   = gnt_hdr;
            out_mdata_d = gnt_mdata;
        end

        // IDs with no matching requester leave every steer bit low.
        if (rsp_valid) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rsp_id == REQ_ID_WIDTH'(i)) begin
                    rsp_valid_o_d[i] = 1'b1;
                end
            end
            rsp_mdata_o_d = {{REQ_ID_WIDTH{1'b0}}, rsp_mdata[LOW_W-1:0]};
            if (outstanding_q == '0) begin
                err_underflow_d = 1'b1;
            end
        end

        case ({handshake, rsp_valid})
            2'b10:   outstanding_d = outstanding_q + CREDIT_WIDTH'(1);
            2'b01:   if (outstanding_q != '0) outstanding_d = outstanding_q - CREDIT_WIDTH'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or negedge bb_softreset_n) begin
        if (!bb_softreset_n) begin
            rr_ptr_q        <= '0;
            out_valid_q     <= 1'b0;
            out_hdr_q       <= '0;
            out_mdata_q     <= '0;
            rsp_valid_o_q   <= '0;
            rsp_mdata_o_q   <= '0;
            outstanding_q   <= '0;
            err_underflow_q <= 1'b0;
        end else begin
            rr_ptr_q        <= rr_ptr_d;
            out_valid_q     <= out_valid_d;
            out_hdr_q       <= out_hdr_d;
            out_mdata_q     <= out_mdata_d;
            rsp_valid_o_q   <= rsp_valid_o_d;
            rsp_mdata_o_q   <= rsp_mdata_o_d;
            outstanding_q   <= outstanding_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_hdr       = out_hdr_q;
    assign out_mdata     = out_mdata_q;
    assign rsp_valid_o   = rsp_valid_o_q;
    assign rsp_mdata_o   = rsp_mdata_o_q;
    assign outstanding   = outstanding_q;
    assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_ccip_rd_req_arbiter.sv
// Bench for ccip_rd_req_arbiter: a random and directed driver with a queue-based
// reference model, and a monitor that pops expected responses as the DUT emits them.
module tb_ccip_rd_req_arbiter;
    localparam int N    = 4;
    localparam int IDW  = 2;
    localparam int HW   = 64;
    localparam int TW   = 16;
    localparam int MAXO = 8;
    localparam int CW   = 4;
    localparam int LOW  = TW - IDW;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*HW-1:0]   req_hdr;
    logic [N*TW-1:0]   req_mdata;
    logic [N-1:0]      req_ready;
    logic              out_valid;
    logic [HW-1:0]     out_hdr;
    logic [TW-1:0]     out_mdata;
    logic              out_almfull;
    logic              rsp_valid;
    logic [TW-1:0]     rsp_mdata;
    logic [N-1:0]      rsp_valid_o;
    logic [TW-1:0]     rsp_mdata_o;
    logic [CW-1:0]     outstanding;
    logic              err_underflow;

    ccip_rd_req_arbiter #(
        .NUM_REQ(N), .REQ_ID_WIDTH(IDW), .HDR_WIDTH(HW), .TAG_WIDTH(TW),
        .MAX_OUTSTANDING(MAXO), .CREDIT_WIDTH(CW)
    ) dut (
        .clk(clk), .bb_softreset_n(rst_n),
        .req_valid(req_valid), .req_hdr(req_hdr), .req_mdata(req_mdata),
        .req_ready(req_ready),
        .out_valid(out_valid), .out_hdr(out_hdr), .out_mdata(out_mdata),
        .out_almfull(out_almfull),
        .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata),
        .rsp_valid_o(rsp_valid_o), .rsp_mdata_o(rsp_mdata_o),
        .outstanding(outstanding), .err_underflow(err_underflow)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model state
    logic [HW-1:0]    pend_hdr [N];
    logic [TW-1:0]    pend_md  [N];
    logic             pend_v   [N];
    int               m_rr;
    int               m_out;
    logic             m_err;
    logic [HW+TW-1:0] exp_q [$];
    logic [N+TW-1:0]  rsp_q [$];
    int               checks;
    int               errors;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
        m_rr  = 0;
        m_out = 0;
        m_err = 1'b0;
        exp_q.delete();
        rsp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        req_valid   = '1;
        out_almfull = 1'b0;
        rsp_valid   = 1'b0;
        #1;
        check("rst_req_ready", req_ready, '0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_mdata", out_mdata, '0);
        check("rst_outstanding", outstanding, '0);
        check("rst_err_underflow", err_underflow, 1'b0);
        check("rst_rsp_valid_o", rsp_valid_o, '0);
        model_clear();
        repeat (2) @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b1;
    endtask

    // driver: one clock of stimulus plus the reference-model update
    task automatic step(input logic [N-1:0] new_mask, input logic af,
                        input logic rv, input logic [TW-1:0] rmd);
        int            g;
        int            idx;
        logic [N-1:0]  exp_rdy;
        logic [N-1:0]  oh;
        logic [IDW-1:0] rid;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (new_mask[i] && !pend_v[i]) begin
                pend_v[i]   = 1'b1;
                pend_hdr[i] = {$urandom, $urandom};
                pend_md[i]  = TW'($urandom);
            end
            req_valid[i]           = pend_v[i];
            req_hdr[i*HW +: HW]    = pend_hdr[i];
            req_mdata[i*TW +: TW]  = pend_md[i];
        end
        out_almfull = af;
        rsp_valid   = rv;
        rsp_mdata   = rmd;
        #1;
        g = -1;
        if (!af && m_out < MAXO) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (g < 0 && pend_v[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", req_ready, exp_rdy);
        if (g >= 0) begin
            exp_q.push_back({pend_hdr[g], IDW'(g), pend_md[g][LOW-1:0]});
            pend_v[g] = 1'b0;
            m_rr      = (g + 1) % N;
        end
        if (rv) begin
            rid = rmd[TW-1 -: IDW];
            oh  = '0;
            if (int'(rid) < N) oh[rid] = 1'b1;
            rsp_q.push_back({oh, {IDW{1'b0}}, rmd[LOW-1:0]});
            if (m_out == 0) m_err = 1'b1;
        end
        if (g >= 0 && !rv) m_out = m_out + 1;
        else if (g < 0 && rv && m_out > 0) m_out = m_out - 1;
    endtask

    // monitor / scoreboard
    initial begin
        logic [HW+TW-1:0] e;
        logic [N+TW-1:0]  r;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n !== 1'b1) continue;
            check("out_valid", out_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (out_valid) check("out_payload", {out_hdr, out_mdata}, e);
            end
            if (rsp_q.size() > 0) begin
                r = rsp_q.pop_front();
                check("rsp_valid_o", rsp_valid_o, r[N+TW-1 -: N]);
                check("rsp_mdata_o", rsp_mdata_o, r[TW-1:0]);
            end else begin
                check("rsp_valid_o_idle", rsp_valid_o, '0);
            end
            check("outstanding", outstanding, m_out);
            check("err_underflow", err_underflow, m_err);
        end
    end

    initial begin
        int guard;
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b1;
        req_valid   = '0;
        req_hdr     = '0;
        req_mdata   = '0;
        out_almfull = 1'b0;
        rsp_valid   = 1'b0;
        rsp_mdata   = '0;
        model_clear();
        do_reset();

        // fairness, then hit the credit limit
        repeat (8) step(4'hF, 1'b0, 1'b0, '0);
        step(4'hF, 1'b0, 1'b0, '0);
        step(4'hF, 1'b0, 1'b1, 16'h8123);
        step(4'hF, 1'b0, 1'b0, '0);

        // response and grant in the same cycle
        step(4'h0, 1'b0, 1'b1, TW'($urandom));
        step(4'hF, 1'b0, 1'b1, TW'($urandom));

        // drain, then a response with nothing outstanding
        guard = 0;
        while ((m_out > 0 || pend_v[0] || pend_v[1] || pend_v[2] || pend_v[3]) && guard < 40) begin
            step(4'h0, 1'b0, 1'b1, TW'($urandom));
            guard++;
        end
        step(4'h0, 1'b0, 1'b1, 16'h4001);
        repeat (2) step(4'h0, 1'b0, 1'b0, '0);

        // almost-full blocks grants
        repeat (3) step(4'hF, 1'b1, 1'b0, '0);
        repeat (2) step(4'hF, 1'b0, 1'b0, '0);

        // reset clears sticky error; skip idle requesters from rr_ptr 0
        do_reset();
        repeat (5) step(4'b1010, 1'b0, 1'b0, '0);

        // randomized traffic
        repeat (400) begin
            step(N'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), TW'($urandom));
        end
        repeat (3) step(4'h0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #2;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ccip_rd_req_arbiter.md
Name: ccip_rd_req_arbiter

Overview:
- Shares the single CCI-P TX0 read-request channel in front of the read reorder buffer between NUM_REQ AFU requesters.
- Arbitrates round-robin and stamps the requester ID into the upper mdata bits.
- Meters outstanding reads against the reorder-buffer depth.
- Steers in-order read responses back to the originating requester with the original mdata restored.

Parameters:
- NUM_REQ, 4, number of requesters.
- REQ_ID_WIDTH, 2, width of requester ID; equals clog2(NUM_REQ).
- HDR_WIDTH, 64, opaque request-header width, excluding mdata.
- TAG_WIDTH, 16, mdata width.
- MAX_OUTSTANDING, 256, read credits; equals reorder-buffer depth.
- CREDIT_WIDTH, 9, outstanding-counter width; holds 0..MAX_OUTSTANDING.

Ports:
- clk  in  1  common clock.
- bb_softreset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester read request valid.
- req_hdr  in  NUM_REQ*HDR_WIDTH  per-requester header; requester i occupies slice i.
- req_mdata  in  NUM_REQ*TAG_WIDTH  per-requester mdata; only the low TAG_WIDTH-REQ_ID_WIDTH bits are significant.
- req_ready  out  NUM_REQ  one-hot grant, combinational.
- out_valid  out  1  read request to the reorder buffer.
- out_hdr  out  HDR_WIDTH  granted header.
- out_mdata  out  TAG_WIDTH  {requester ID, low mdata bits}.
- out_almfull  in  1  downstream C0TxAlmFull.
- rsp_valid  in  1  in-order read response from the reorder buffer.
- rsp_mdata  in  TAG_WIDTH  response mdata.
- rsp_valid_o  out  NUM_REQ  one-hot response steer.
- rsp_mdata_o  out  TAG_WIDTH  restored mdata; upper REQ_ID_WIDTH bits forced to 0.
- outstanding  out  CREDIT_WIDTH  current in-flight read count.
- err_underflow  out  1  sticky: response received with zero outstanding.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - Registered outputs to 0: out_valid, out_hdr, out_mdata, rsp_valid_o, rsp_mdata_o, outstanding, err_underflow.
  - rr_ptr = 0.
  - req_ready = 0 while reset is asserted.
- can_issue = ~out_almfull & (outstanding < MAX_OUTSTANDING).
  - A response in the same cycle does not free a credit for this cycle's grant.
- Arbitration:
  - When can_issue, grant the first asserted req_valid searching from index rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready[g] = 1 combinationally; at most one bit is set.
  - A handshake occurs when req_valid[g] & req_ready[g].
  - Requesters hold valid and payload until they see ready.
  - After a grant to g, rr_ptr = (g+1) mod NUM_REQ.
  - With no grant, rr_ptr is unchanged.
- Issue pipeline (latency 1): the cycle after a handshake:
  - out_valid = 1.
  - out_hdr = req_hdr[g].
  - out_mdata = {g[REQ_ID_WIDTH-1:0], req_mdata[g][TAG_WIDTH-REQ_ID_WIDTH-1:0]}.
  - Otherwise out_valid = 0 and the payload holds its last value.
- Credit counter, updated each clock:
  - +1 on handshake.
  - -1 on rsp_valid.
  - Unchanged when both or neither occur.
  - Never exceeds MAX_OUTSTANDING, guaranteed by can_issue.
  - rsp_valid with outstanding == 0: counter stays 0 and err_underflow is set; it clears only on reset.
- Response steer (latency 1): the cycle after rsp_valid:
  - rsp_valid_o[rsp_mdata[TAG_WIDTH-1:TAG_WIDTH-REQ_ID_WIDTH]] = 1.
  - rsp_mdata_o = {REQ_ID_WIDTH'b0, rsp_mdata[TAG_WIDTH-REQ_ID_WIDTH-1:0]}.
  - If the ID is >= NUM_REQ (non-power-of-2 NUM_REQ), no bit of rsp_valid_o is set.
- Response steering is independent of arbitration and out_almfull; responses are never back-pressured.
- out_almfull asserted mid-burst: no grant in any cycle where it is high; an already-registered out_valid still issues.
- Reset mid-operation: in-flight state is discarded; the counter restarts at 0. The owner must reset the reorder buffer concurrently.

Test Plan:
- Reset: hold bb_softreset_n=0 with req_valid=4'hF -> req_ready=0, out_valid=0, outstanding=0.
- Fairness: req_valid=4'hF for 8 cycles, almfull=0 -> grant order 0,1,2,3,0,1,2,3; out_mdata[15:14] matches; outstanding=8.
- Skip idle: req_valid=4'b1010 from rr_ptr=0 -> grants 1,3,1,3; rr_ptr wraps 3->0 and next grant goes to 1.
- Credit limit: MAX_OUTSTANDING=4, 6 continuous requests, no responses -> exactly 4 handshakes, outstanding=4, req_ready=0. A single rsp_valid -> outstanding=3 next cycle, one more grant the cycle after.
- Simultaneous events: handshake and rsp_valid in the same cycle with outstanding=5 -> outstanding stays 5.
- Response steer and errors:
  - rsp_mdata=16'h8123 -> next cycle rsp_valid_o=4'b0100, rsp_mdata_o=16'h0123.
  - rsp_valid with outstanding=0 -> err_underflow=1 and sticky until reset.
  - out_almfull=1 -> no grants during it.
